smul_seq_ctrl: RTL and testbench

//  Sequencer for one smul sub-MAC unit. Drives smul's ce/sclr/select_precision/enable_fp_unit/active_chain.

---
 rtl/smul_seq_ctrl_if.sv | 23 ++
 rtl/smul_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_smul_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/smul_seq_ctrl_if.sv
// Scheduler-side handshakes of the smul sequencer: config request, operand beats, results.
// The master is the tile scheduler, the slave is smul_seq_ctrl.
interface smul_seq_ctrl_if;
    logic       cfg_load;
    logic [2:0] cfg_prec;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output cfg_load, cfg_prec, in_valid, in_last, out_ready,
        input  cfg_err, in_ready, out_valid, out_last
    );

    modport slave (
        input  cfg_load, cfg_prec, in_valid, in_last, out_ready,
        output cfg_err, in_ready, out_valid, out_last
    );
endinterface

// File: rtl/smul_seq_ctrl.sv
// Sequencer for one smul sub-MAC: valid/last tag pipe, backpressure stall, drain/flush reconfig.
// Optional perf counters are built when SMUL_SEQ_PERF_EN is defined.
module smul_seq_ctrl #(
    parameter int unsigned LAT_INT      = 3,
    parameter int unsigned LAT_FP       = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    smul_seq_ctrl_if.slave        bus,
    output logic                  busy,
    output logic                  smul_ce,
    output logic                  smul_sclr,
    output logic [3:0]            smul_sel_prec,
    output logic [1:0]            smul_en_fp,
    output logic                  smul_active_chain,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall
);

    localparam int unsigned DEPTH      = (LAT_INT > LAT_FP) ? LAT_INT : LAT_FP;
    localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [2:0]       pend_q, pend_d;
    logic [3:0]       sel_q, sel_d;
    logic [1:0]       en_fp_q, en_fp_d;
    logic             chain_q, chain_d;
    logic             is_fp_q;
    logic             cfg_err_q;
    logic [DEPTH-1:0] vld_q, lst_q;

    logic       cfg_ok, cfg_bad;
    logic       tap_vld, tap_lst;
    logic       stall, accept, pipe_empty;
    logic       in_ready_w;
    logic       load_prec;
    logic [2:0] load_code;

    assign cfg_ok  = bus.cfg_load & (bus.cfg_prec <= 3'd5);
    assign cfg_bad = bus.cfg_load & (bus.cfg_prec > 3'd5);

    // Output tap follows the precision the datapath is currently running at.
    assign tap_vld = is_fp_q ? vld_q[LAT_FP-1] : vld_q[LAT_INT-1];
    assign tap_lst = is_fp_q ? lst_q[LAT_FP-1] : lst_q[LAT_INT-1];
    assign stall   = tap_vld & ~bus.out_ready;
    assign accept  = bus.in_valid & in_ready_w;

    // Stages past the active tap hold already-delivered tags and do not count.
    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (i < (is_fp_q ? LAT_FP : LAT_INT))) begin
                pipe_empty = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        load_prec   = 1'b0;
        load_code   = pend_q;
        smul_ce     = 1'b0;
        smul_sclr   = 1'b0;
        in_ready_w  = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_ok) begin
                    load_prec   = 1'b1;
                    load_code   = bus.cfg_prec;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                smul_sclr = 1'b1;
                busy      = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            StRun: begin
                smul_ce    = ~stall;
                in_ready_w = ~stall;
                if (cfg_ok) begin
                    pend_d  = bus.cfg_prec;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy    = 1'b1;
                smul_ce = ~stall;
                if (pipe_empty) begin
                    load_prec   = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d   = '0;
        en_fp_d = '0;
        case (load_code)
            3'd0:    sel_d   = 4'b0001;
            3'd1:    sel_d   = 4'b0010;
            3'd2:    sel_d   = 4'b0100;
            3'd3:    sel_d   = 4'b1000;
            3'd4:    en_fp_d = 2'b01;
            3'd5:    en_fp_d = 2'b11;
            default: ;
        endcase
        chain_d = (load_code == 3'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            pend_q      <= '0;
            sel_q       <= '0;
            en_fp_q     <= '0;
            chain_q     <= 1'b0;
            is_fp_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            vld_q       <= '0;
            lst_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            cfg_err_q   <= cfg_bad;
            if (load_prec) begin
                sel_q   <= sel_d;
                en_fp_q <= en_fp_d;
                chain_q <= chain_d;
                is_fp_q <= en_fp_d[0];
            end
            // The flush also clears stale tags left beyond the old tap.
            if (state_q == StFlush) begin
                vld_q <= '0;
                lst_q <= '0;
            end else if (smul_ce) begin
                vld_q <= {vld_q[DEPTH-2:0], accept};
                lst_q <= {lst_q[DEPTH-2:0], accept & bus.in_last};
            end
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = tap_vld;
    assign bus.out_last   = tap_lst;
    assign bus.cfg_err    = cfg_err_q;
    assign smul_sel_prec     = sel_q;
    assign smul_en_fp        = en_fp_q;
    assign smul_active_chain = chain_q;

`ifdef SMUL_SEQ_PERF_EN
    logic [31:0] ops_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (accept) begin
                ops_q <= ops_q + 32'd1;
            end
            if (stall && (state_q == StRun || state_q == StDrain)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_smul_seq_ctrl.sv
// Directed bench for smul_seq_ctrl: vector table for the INT8 run, hand sequences for the rest.
module tb_smul_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        busy;
    logic        smul_ce;
    logic        smul_sclr;
    logic [3:0]  smul_sel_prec;
    logic [1:0]  smul_en_fp;
    logic        smul_active_chain;
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    int n_cmp = 0;
    int n_bad = 0;

    smul_seq_ctrl_if bus_if ();

    smul_seq_ctrl #(
        .LAT_INT      (3),
        .LAT_FP       (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus_if),
        .busy              (busy),
        .smul_ce           (smul_ce),
        .smul_sclr         (smul_sclr),
        .smul_sel_prec     (smul_sel_prec),
        .smul_en_fp        (smul_en_fp),
        .smul_active_chain (smul_active_chain),
        .perf_ops          (perf_ops),
        .perf_stall        (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {out_valid, out_last, in_ready, ce, sclr, busy, cfg_err}
    typedef struct {
        logic       cfg_load;
        logic [2:0] cfg_prec;
        logic       in_valid;
        logic       in_last;
        logic       out_ready;
        logic [6:0] exp;
    } vec_t;

    vec_t t1 [15];

`ifdef SMUL_SEQ_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
    localparam logic [31:0] EXP_OPS   = 32'd16;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_OPS   = 32'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {bus_if.out_valid, bus_if.out_last, bus_if.in_ready, smul_ce, smul_sclr, busy,
                bus_if.cfg_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cl, input logic [2:0] cp, input logic iv, input logic il,
                         input logic ordy);
        bus_if.cfg_load  = cl;
        bus_if.cfg_prec  = cp;
        bus_if.in_valid  = iv;
        bus_if.in_last   = il;
        bus_if.out_ready = ordy;
    endtask

    // Issue a config request from RUN and wait (bounded) until the unit is back in RUN.
    task automatic reconfig(input logic [2:0] code);
        int n;
        drive(1'b1, code, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("reconfig_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] e;
        logic       seen;

        t1[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0000000};
        t1[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0000110};
        t1[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0000110};
        t1[3]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b0011000};
        t1[4]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b0011000};
        t1[5]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b0011000};
        t1[6]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b1011000};
        t1[7]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b1011000};
        t1[8]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b1011000};
        t1[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 7'b1011000};
        t1[10] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 7'b1011000};
        t1[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b1011000};
        t1[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b1011000};
        t1[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b1111000};
        t1[14] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011000};

        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("reset_outs", {25'd0, outs()}, 32'd0);
        check("reset_sel", {25'd0, smul_sel_prec, smul_en_fp, smul_active_chain}, 32'd0);
        reset = 1'b0;

        // T1: INT8, 8 back-to-back beats
        for (int i = 0; i < 15; i++) begin
            drive(t1[i].cfg_load, t1[i].cfg_prec, t1[i].in_valid, t1[i].in_last,
                  t1[i].out_ready);
            #1;
            check($sformatf("t1_row%0d", i), {25'd0, outs()}, {25'd0, t1[i].exp});
            if (i == 1) check("t1_sel_int8", {28'd0, smul_sel_prec}, 32'h1);
            step();
        end

        // T2: FP32, 4 beats, 5-cycle backpressure at the first result
        reconfig(3'd4);
        check("t2_prec", {25'd0, smul_sel_prec, smul_en_fp, smul_active_chain}, 32'b0000_01_0);
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 3'd0, c < 4, c == 3, !(c >= 4 && c <= 8));
            #1;
            e = {(c >= 4 && c <= 12), (c == 12), !(c >= 4 && c <= 8), !(c >= 4 && c <= 8),
                 1'b0, 1'b0, 1'b0};
            check($sformatf("t2_c%0d", c), {25'd0, outs()}, {25'd0, e});
            step();
        end
        check("t2_perf_stall", perf_stall, EXP_STALL);

        // T3: INT16 run, switch to INT64 with beats in flight
        reconfig(3'd1);
        for (int c = 0; c < 10; c++) begin
            drive(c == 2, 3'd3, c <= 2, c == 2, 1'b1);
            #1;
            e = {(c >= 3 && c <= 5), (c == 5), (c <= 2 || c == 9), !(c == 7 || c == 8),
                 (c == 7 || c == 8), (c >= 3 && c <= 8), 1'b0};
            check($sformatf("t3_c%0d", c), {25'd0, outs()}, {25'd0, e});
            if (c == 0) check("t3_sel_int16", {28'd0, smul_sel_prec}, 32'h2);
            if (c == 7) check("t3_sel_int64", {27'd0, smul_sel_prec, smul_active_chain}, 32'h11);
            step();
        end

        // T4: invalid code in RUN
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 3'd6, 1'b0, 1'b0, 1'b1);
            #1;
            e = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, (c == 1)};
            check($sformatf("t4_c%0d", c), {25'd0, outs()}, {25'd0, e});
            step();
        end
        check("t4_sel_kept", {27'd0, smul_sel_prec, smul_active_chain}, 32'h11);

        // T6: BF16, latency 4
        reconfig(3'd5);
        check("t6_prec", {25'd0, smul_sel_prec, smul_en_fp, smul_active_chain}, 32'b0000_11_0);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 3'd0, c == 0, c == 0, 1'b1);
            #1;
            check($sformatf("t6_ov_c%0d", c), {30'd0, bus_if.out_valid, bus_if.out_last},
                  (c == 4) ? 32'h3 : 32'h0);
            step();
        end
        check("t6_perf_ops", perf_ops, EXP_OPS);

        // T5: reset with 2 beats in flight
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("t5_outs", {25'd0, outs()}, 32'd0);
        check("t5_sel", {25'd0, smul_sel_prec, smul_en_fp, smul_active_chain}, 32'd0);
        check("t5_perf", perf_ops | perf_stall, 32'd0);
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            seen = seen | bus_if.out_valid | bus_if.in_ready | busy | smul_ce;
            step();
        end
        check("t5_idle_after", {31'd0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
